// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS fetch stage and the control decoder.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JREG   = 2'd3
  } ctrl_pc_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/mips_cpu_fetch_if.sv
// Instruction bus and decoder handshake seen by the fetch stage.
interface mips_cpu_fetch_if
  import mips_cpu_pkg::*;
  ();

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  ctrl_pc_t    ctrl_pc;
  logic [31:0] reg_rs_data;

  modport master (
    output mem_address, mem_read, instr, instr_pc, instr_valid,
    input  mem_waitrequest, mem_readdata, instr_ready, ctrl_pc, reg_rs_data
  );

  modport slave (
    input  mem_address, mem_read, instr, instr_pc, instr_valid,
    output mem_waitrequest, mem_readdata, instr_ready, ctrl_pc, reg_rs_data
  );

endinterface

// File: rtl/mips_cpu_pc_target.sv
// Combinational control-transfer target: branch, J/JAL region jump, or JR register.
module mips_cpu_pc_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  ctrl_pc_t    ctrl_pc,
  input  logic [31:0] reg_rs_data,
  output logic [31:0] target
);

  function automatic logic [31:0] branch_target(input logic [31:0] pc_next,
                                                input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = signed'({{14{imm[15]}}, imm, 2'b00});
    return pc_next + $unsigned(offset);
  endfunction

  logic [31:0] pc_next;
  logic [31:0] raw;

  assign pc_next = instr_pc + 32'd4;

  always_comb begin
    raw = pc_next;
    case (ctrl_pc)
      PC_BRANCH: raw = branch_target(pc_next, instr[15:0]);
      PC_JUMP:   raw = {pc_next[31:28], instr[25:0], 2'b00};
      PC_JREG:   raw = reg_rs_data;
      default:   raw = pc_next;
    endcase
  end

  // Opcode bits of instr only matter to the decoder; masking keeps targets word aligned.
  assign target = raw & {30'h3FFF_FFFF, 2'b00} | {26'd0, instr[31:26] & 6'd0};

endmodule

// File: rtl/mips_cpu_fetch.sv
// Fetch stage: owns the PC, reads instructions over the bus, applies delay-slot transfers.
module mips_cpu_fetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              active,
  mips_cpu_fetch_if.master  bus
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         mem_read, mem_read_nxt;
  logic [31:0]  instr, instr_nxt;
  logic [31:0]  instr_pc, instr_pc_nxt;
  logic         instr_valid, instr_valid_nxt;
  logic         active_nxt;
  logic         delay_pending, delay_pending_nxt;
  logic [31:0]  target, target_nxt, target_calc;
  logic         retire;

  mips_cpu_pc_target u_target (
    .instr       (instr),
    .instr_pc    (instr_pc),
    .ctrl_pc     (bus.ctrl_pc),
    .reg_rs_data (bus.reg_rs_data),
    .target      (target_calc)
  );

  assign retire = instr_valid & bus.instr_ready;

  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    mem_read_nxt      = mem_read;
    instr_nxt         = instr;
    instr_pc_nxt      = instr_pc;
    instr_valid_nxt   = instr_valid;
    active_nxt        = active;
    delay_pending_nxt = delay_pending;
    target_nxt        = target;
    case (state)
      ST_FETCH: begin
        if (!mem_read) begin
          mem_read_nxt = 1'b1;
        end else if (!bus.mem_waitrequest) begin
          instr_nxt       = bus.mem_readdata;
          instr_pc_nxt    = pc;
          instr_valid_nxt = 1'b1;
          mem_read_nxt    = 1'b0;
          state_nxt       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (retire) begin
          instr_valid_nxt = 1'b0;
          if (delay_pending) begin
            // Slot retired: the latched target wins, and a transfer to 0 ends the program.
            delay_pending_nxt = 1'b0;
            if (target == 32'd0) begin
              active_nxt = 1'b0;
              state_nxt  = ST_HALTED;
            end else begin
              pc_nxt       = target;
              mem_read_nxt = 1'b1;
              state_nxt    = ST_FETCH;
            end
          end else begin
            pc_nxt       = pc + 32'd4;
            mem_read_nxt = 1'b1;
            state_nxt    = ST_FETCH;
            if (bus.ctrl_pc != PC_SEQ) begin
              target_nxt        = target_calc;
              delay_pending_nxt = 1'b1;
            end
          end
        end
      end
      ST_HALTED: begin
        mem_read_nxt    = 1'b0;
        instr_valid_nxt = 1'b0;
        active_nxt      = 1'b0;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_FETCH;
      pc            <= RESET_VECTOR;
      mem_read      <= 1'b0;
      instr         <= 32'd0;
      instr_pc      <= 32'd0;
      instr_valid   <= 1'b0;
      active        <= 1'b1;
      delay_pending <= 1'b0;
      target        <= 32'd0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      mem_read      <= mem_read_nxt;
      instr         <= instr_nxt;
      instr_pc      <= instr_pc_nxt;
      instr_valid   <= instr_valid_nxt;
      active        <= active_nxt;
      delay_pending <= delay_pending_nxt;
      target        <= target_nxt;
    end
  end

  assign bus.mem_address = pc;
  assign bus.mem_read    = mem_read;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Table-driven bench for mips_cpu_fetch with a fetch scoreboard and halt/reset sequences.
module tb_mips_cpu_fetch;
  import mips_cpu_pkg::*;

  typedef struct {
    bit          rst_before;
    logic [31:0] addr;
    logic [31:0] word;
    int          waits;
    int          hold;
    ctrl_pc_t    ctrl;
    logic [31:0] rs;
    bit          halt_after;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic active;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  exp_t sb[$];

  mips_cpu_fetch_if bus();

  mips_cpu_fetch #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (active),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit rb, input logic [31:0] a, input logic [31:0] w, input int wt,
                     input int h, input ctrl_pc_t c, input logic [31:0] rs, input bit halt,
                     input bit pk);
    vec_t v;
    v.rst_before = rb; v.addr = a; v.word = w; v.waits = wt; v.hold = h;
    v.ctrl = c; v.rs = rs; v.halt_after = halt; v.poke = pk;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata    = 32'hDEAD_BEEF;
    bus.instr_ready     = 1'b0;
    bus.ctrl_pc         = PC_SEQ;
    bus.reg_rs_data     = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_ctrl", {29'd0, bus.mem_read, bus.instr_valid, active}, 32'd1);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_address", bus.mem_address, 32'hBFC0_0000);
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic serve(input logic [31:0] addr, input logic [31:0] word, input int waits,
                       input bit poke, input int exp_lat);
    int t;
    exp_t e;
    t = 0;
    while (!bus.mem_read && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("fetch_latency", t, exp_lat);
    if (!bus.mem_read) return;
    check("mem_address", bus.mem_address, addr);
    bus.mem_readdata = word;
    for (int i = 0; i < waits; i++) begin
      bus.mem_waitrequest = 1'b1;
      if (poke) begin
        bus.instr_ready = 1'b1;
        bus.ctrl_pc     = PC_JREG;
        bus.reg_rs_data = 32'h0;
      end
      @(negedge clk);
      check("wait_stable", {bus.mem_address[30:0], bus.mem_read},
            {addr[30:0], 1'b1});
      check("wait_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.mem_waitrequest = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.ctrl_pc         = PC_SEQ;
    e.pc = addr;
    e.word = word;
    sb.push_back(e);
    @(negedge clk);
    bus.mem_readdata = 32'hDEAD_BEEF;
    check("valid_rise", {29'd0, bus.instr_valid, bus.mem_read, active}, 32'd5);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("instr", bus.instr, e.word);
      check("instr_pc", bus.instr_pc, e.pc);
    end
  endtask

  task automatic retire(input logic [31:0] word, input int hold, input ctrl_pc_t c,
                        input logic [31:0] rs);
    for (int i = 0; i < hold; i++) begin
      bus.instr_ready = 1'b0;
      bus.ctrl_pc     = ctrl_pc_t'($urandom_range(3));
      bus.reg_rs_data = $urandom;
      @(negedge clk);
      check("hold_instr", bus.instr, word);
      check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    end
    bus.instr_ready = 1'b1;
    bus.ctrl_pc     = c;
    bus.reg_rs_data = rs;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.ctrl_pc     = PC_SEQ;
    bus.reg_rs_data = $urandom;
  endtask

  task automatic check_halt();
    int reads;
    check("halt_state", {30'd0, active, bus.instr_valid}, 32'd0);
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_read) reads++;
    end
    check("halt_no_reads", reads, 32'd0);
    check("halt_active", {31'd0, active}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    // rst addr word waits hold ctrl rs halt poke
    add(1, 32'hBFC0_0000, 32'h3C01_0001, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hBFC0_0004, 32'h2421_0002, 3, 4, PC_SEQ,    32'h0,         0, 1);
    add(0, 32'hBFC0_0008, 32'h0000_0000, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hBFC0_000C, 32'h0000_0001, 0, 1, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hBFC0_0010, 32'h1000_0004, 0, 0, PC_BRANCH, 32'h0,         0, 0);
    add(0, 32'hBFC0_0014, 32'h0000_0020, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hBFC0_0024, 32'h0BF0_0040, 0, 0, PC_JUMP,   32'h0,         0, 0);
    add(0, 32'hBFC0_0028, 32'h0040_0008, 0, 0, PC_JREG,   32'h0,         0, 0);
    add(0, 32'hBFC0_0100, 32'h0000_0002, 1, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hBFC0_0104, 32'h1000_FFFC, 0, 0, PC_BRANCH, 32'h0,         0, 0);
    add(0, 32'hBFC0_0108, 32'h0000_0003, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hBFC0_00F8, 32'h0020_0008, 0, 2, PC_JREG,   32'h8000_0123, 0, 0);
    add(0, 32'hBFC0_00FC, 32'h0000_0004, 2, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'h8000_0120, 32'h0000_0005, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'h8000_0124, 32'h0000_0008, 0, 0, PC_JREG,   32'h0,         0, 0);
    add(0, 32'h8000_0128, 32'h0000_0006, 0, 0, PC_SEQ,    32'h0,         1, 0);
    add(1, 32'hBFC0_0000, 32'h0000_0008, 0, 0, PC_JREG,   32'h0,         0, 0);
    add(0, 32'hBFC0_0004, 32'h0000_0007, 0, 0, PC_SEQ,    32'h0,         1, 0);
    add(1, 32'hBFC0_0000, 32'h0000_0008, 0, 0, PC_JREG,   32'hFFFF_FFFC, 0, 0);
    add(0, 32'hBFC0_0004, 32'h0000_0009, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'hFFFF_FFFC, 32'h0000_000A, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'h0000_0000, 32'h0000_000B, 1, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'h0000_0004, 32'h0800_0010, 0, 0, PC_JUMP,   32'h0,         0, 0);
    add(0, 32'h0000_0008, 32'h0000_000C, 0, 0, PC_SEQ,    32'h0,         0, 0);
    add(0, 32'h0000_0040, 32'h1000_FFEF, 0, 0, PC_BRANCH, 32'h0,         0, 0);
    add(0, 32'h0000_0044, 32'h0000_000D, 0, 0, PC_SEQ,    32'h0,         1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      serve(tbl[i].addr, tbl[i].word, tbl[i].waits, tbl[i].poke, tbl[i].rst_before ? 1 : 0);
      retire(tbl[i].word, tbl[i].hold, tbl[i].ctrl, tbl[i].rs);
      if (tbl[i].halt_after) check_halt();
    end

    // Reset arriving while a read is stalled by waitrequest.
    do_reset();
    for (int t = 0; t < 50 && !bus.mem_read; t++) @(negedge clk);
    bus.mem_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    check("midread_req", {31'd0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midread_abort", {30'd0, bus.mem_read, bus.instr_valid}, 32'd0);
    @(negedge clk);
    bus.mem_waitrequest = 1'b0;
    sb.delete();
    rst_n = 1'b1;
    serve(32'hBFC0_0000, 32'h2402_0005, 0, 0, 1);
    retire(32'h2402_0005, 0, PC_SEQ, 32'h0);
    serve(32'hBFC0_0004, 32'h2403_0006, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
